ifetch_stage: RTL

- Instruction-fetch stage of the 5-stage RISC-V pipeline.
- Owns the 9-bit program counter and issues requests to instruction memory over a req/ack handshake that can take a variable number of cycles.
- Fills the IF/ID pipeline register (Pipe_Buf_Reg_PKG::if_id_reg: Curr_Pc, Curr_Instr).
- Honours stall and branch/jump redirect from downstream, and stops fetching permanently after halt.

---
 rtl/ifetch_stage.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory over a
// variable-latency req/ack handshake and fills the IF/ID pipeline register.
module ifetch_stage #(
  parameter int              PC_W      = 9,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt_in,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic [PC_W+31:0]   if_id_out,
  output logic               if_id_valid,
  output logic               halted
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_HOLD   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
  logic              drop_q, drop_d;
  logic [31:0]       hold_instr_q, hold_instr_d;
  logic [PC_W+31:0]  if_id_q, if_id_d;
  logic              valid_q, valid_d;

  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   redirect_aligned;
  logic [PC_W+31:0]  bubble;

  assign pc_inc           = pc_q + PC_W'(4);
  assign redirect_aligned = {redirect_pc[PC_W-1:2], 2'b00};
  assign bubble           = {pc_q, NOP_INSTR};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      pend_pc_q    <= RESET_PC;
      drop_q       <= 1'b0;
      hold_instr_q <= '0;
      if_id_q      <= {{PC_W{1'b0}}, NOP_INSTR};
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      drop_q       <= drop_d;
      hold_instr_q <= hold_instr_d;
      if_id_q      <= if_id_d;
      valid_q      <= valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    drop_d       = drop_q;
    hold_instr_d = hold_instr_q;
    if_id_d      = if_id_q;
    valid_d      = valid_q;
    if (halt_in) begin
      state_d = S_HALTED;
      drop_d  = 1'b0;
      if_id_d = bubble;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (redirect) begin
            // A redirect with no ack must wait for the in-flight response to drain.
            if (imem_ack) begin
              pc_d   = redirect_aligned;
              drop_d = 1'b0;
            end else begin
              pend_pc_d = redirect_aligned;
              drop_d    = 1'b1;
            end
            if (!stall) begin
              if_id_d = bubble;
              valid_d = 1'b0;
            end
          end else if (imem_ack && drop_q) begin
            pc_d   = pend_pc_q;
            drop_d = 1'b0;
            if (!stall) begin
              if_id_d = bubble;
              valid_d = 1'b0;
            end
          end else if (imem_ack && stall) begin
            hold_instr_d = imem_rdata;
            state_d      = S_HOLD;
          end else if (imem_ack) begin
            if_id_d = {pc_q, imem_rdata};
            valid_d = 1'b1;
            pc_d    = pc_inc;
          end else if (!stall) begin
            if_id_d = bubble;
            valid_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (redirect) begin
            pc_d    = redirect_aligned;
            drop_d  = 1'b0;
            state_d = S_FETCH;
            if (!stall) begin
              if_id_d = bubble;
              valid_d = 1'b0;
            end
          end else if (!stall) begin
            if_id_d = {pc_q, hold_instr_q};
            valid_d = 1'b1;
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end
        end
        S_HALTED: begin
          if_id_d = bubble;
          valid_d = 1'b0;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_comb begin
    imem_req    = (state_q == S_FETCH) && !reset;
    imem_addr   = {pc_q[PC_W-1:2], 2'b00};
    if_id_out   = if_id_q;
    if_id_valid = valid_q;
    halted      = (state_q == S_HALTED);
  end

endmodule
